// File: rtl/mc_ctrl_fsm_pkg.sv
// -----------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multicycle control FSM: state encoding, opcode and
// funct constants, ALU operation / operand-B select codes, trap causes and the
// packed bundle of control strobes produced by the output decode.
// -----------------------------------------------------------------------------
package mc_ctrl_pkg;

    // Controller states; the encoding is visible on state_dbg.
    typedef enum logic [3:0] {
        RST       = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        R_EXEC    = 4'd7,
        R_WB      = 4'd8,
        I_EXEC    = 4'd9,
        I_WB      = 4'd10,
        BRANCH    = 4'd11,
        JUMP      = 4'd12,
        TRAP      = 4'd13
    } state_e;

    // Opcodes (IR[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (IR[5:0]).
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_AND = 3'd1,
        ALU_OR  = 3'd2,
        ALU_SLT = 3'd3
    } alu_op_e;

    typedef enum logic [2:0] {
        SRC_B_REG    = 3'd0,
        SRC_B_FOUR   = 3'd1,
        SRC_B_IMM    = 3'd2,
        SRC_B_IMM_SH = 3'd3,
        SRC_B_NOT_B  = 3'd4
    } alu_src_b_e;

    typedef enum logic [1:0] {
        PC_SRC_ALU    = 2'd0,
        PC_SRC_ALUOUT = 2'd1,
        PC_SRC_JUMP   = 2'd2
    } pc_src_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_ILLEGAL = 2'd1,
        CAUSE_TIMEOUT = 2'd2
    } trap_cause_e;

    // All control strobes decoded from the state register.
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       alu_src_a;
        alu_src_b_e alu_src_b;
        alu_op_e    alu_op;
        logic       alu_cin;
        logic       pc_write;
        logic       pc_write_cond;
        pc_src_e    pc_src;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       trap;
    } ctrl_t;

    // True for the R-type functions this controller implements.
    function automatic logic is_legal_funct(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
               (funct == FN_OR)  || (funct == FN_SLT);
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// -----------------------------------------------------------------------------
// mc_ctrl_fsm_if
// Bundle between the control FSM (master) and the datapath/memory side (slave).
//   From datapath : opcode, funct, alu_zero, mem_ready
//   To memory     : mem_req, mem_we, iord
//   To datapath   : ir_write, alu_src_a, alu_src_b, alu_op, alu_cin, pc_write,
//                   pc_write_cond, pc_src, reg_write, reg_dst, mem_to_reg
//   Status        : trap, trap_cause, state_dbg
// -----------------------------------------------------------------------------
interface mc_ctrl_fsm_if;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       alu_zero;
    logic       mem_ready;

    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       alu_src_a;
    logic [2:0] alu_src_b;
    logic [2:0] alu_op;
    logic       alu_cin;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       trap;
    logic [1:0] trap_cause;
    logic [3:0] state_dbg;

    modport master (
        input  opcode, funct, alu_zero, mem_ready,
        output mem_req, mem_we, iord, ir_write, alu_src_a, alu_src_b, alu_op,
               alu_cin, pc_write, pc_write_cond, pc_src, reg_write, reg_dst,
               mem_to_reg, trap, trap_cause, state_dbg
    );

    modport slave (
        output opcode, funct, alu_zero, mem_ready,
        input  mem_req, mem_we, iord, ir_write, alu_src_a, alu_src_b, alu_op,
               alu_cin, pc_write, pc_write_cond, pc_src, reg_write, reg_dst,
               mem_to_reg, trap, trap_cause, state_dbg
    );

endinterface

// File: rtl/mc_ctrl_fsm_watchdog.sv
// -----------------------------------------------------------------------------
// mc_ctrl_watchdog
// Counts consecutive cycles a memory access has been waiting and flags expiry
// on the cycle the count reaches MEM_TIMEOUT. MEM_TIMEOUT = 0 disables it.
//   clk, reset_n   : clock, asynchronous active-low reset
//   count_en_i     : in a memory-wait state with mem_ready low this cycle
//   clear_i        : the FSM changes state at the next edge
//   expired_o      : this waiting cycle is the MEM_TIMEOUT-th one
// -----------------------------------------------------------------------------
module mc_ctrl_watchdog #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8     // must be wide enough to hold MEM_TIMEOUT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic count_en_i,
    input  logic clear_i,
    output logic expired_o
);

    logic [TO_W-1:0] count_q;
    logic [TO_W:0]   count_next;   // one extra bit so the compare never wraps

    assign count_next = {1'b0, count_q} + (TO_W+1)'(1);

    // count_q holds the number of earlier waiting cycles, so count_next is the
    // count including the current one. mem_ready suppresses count_en_i, which
    // is how a response on the final cycle wins over the timeout.
    assign expired_o = (MEM_TIMEOUT != 0) && count_en_i &&
                       (count_next == (TO_W+1)'(MEM_TIMEOUT));

    // NOTE: state is updated with non-blocking assignments so every register
    // samples values from before the edge, independent of process order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (count_en_i && (count_q != {TO_W{1'b1}})) begin
            count_q <= count_next[TO_W-1:0];
        end
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// mc_ctrl_fsm
// Multicycle control FSM for an add/sub/and/or/slt, addi, lw, sw, beq, j
// subset. Sits directly upstream of the ALU operand-B mux and drives the ALU
// op, carry-in, PC, IR, memory and register-file strobes.
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset; every strobe drops immediately
//   ctrl     : mc_ctrl_fsm_if.master (instruction fields, memory handshake,
//              datapath strobes, trap status, state_dbg)
// Outputs are a Moore decode of the state register, except ir_write/pc_write
// in FETCH and the exits from memory states, which also depend on mem_ready.
// -----------------------------------------------------------------------------
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    mc_ctrl_fsm_if.master  ctrl
);

    state_e      state_q, state_d;
    trap_cause_e cause_q, cause_d;
    ctrl_t       strobes;

    logic in_wait;
    logic wd_expired;
    logic unused_alu_zero;

    // The branch decision is the datapath's AND of pc_write_cond and alu_zero;
    // the controller itself never needs the flag.
    assign unused_alu_zero = ctrl.alu_zero;

    assign in_wait = (state_q == FETCH) || (state_q == MEM_READ) ||
                     (state_q == MEM_WRITE);

    mc_ctrl_watchdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TO_W        (TO_W)
    ) u_watchdog (
        .clk        (clk),
        .reset_n    (reset_n),
        .count_en_i (in_wait && !ctrl.mem_ready),
        .clear_i    (state_d != state_q),
        .expired_o  (wd_expired)
    );

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RST;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    // --------------------------------------------------------------- next state
    always_comb begin
        // NOTE: defaults first, so every path assigns every variable and no
        // latch is inferred.
        state_d = state_q;
        cause_d = cause_q;

        unique case (state_q)
            RST: state_d = FETCH;

            FETCH: begin
                if (ctrl.mem_ready) begin
                    state_d = DECODE;
                end else if (wd_expired) begin
                    state_d = TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end

            DECODE: begin
                case (ctrl.opcode)
                    OP_RTYPE: begin
                        if (is_legal_funct(ctrl.funct)) begin
                            state_d = R_EXEC;
                        end else begin
                            state_d = TRAP;
                            cause_d = CAUSE_ILLEGAL;
                        end
                    end
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_ADDI:      state_d = I_EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d = TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end

            // Only lw and sw reach MEM_ADDR, so anything not lw is a store.
            MEM_ADDR: state_d = (ctrl.opcode == OP_LW) ? MEM_READ : MEM_WRITE;

            MEM_READ: begin
                if (ctrl.mem_ready) begin
                    state_d = MEM_WB;
                end else if (wd_expired) begin
                    state_d = TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end

            MEM_WRITE: begin
                if (ctrl.mem_ready) begin
                    state_d = FETCH;
                end else if (wd_expired) begin
                    state_d = TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end

            MEM_WB:  state_d = FETCH;
            R_EXEC:  state_d = R_WB;
            R_WB:    state_d = FETCH;
            I_EXEC:  state_d = I_WB;
            I_WB:    state_d = FETCH;
            BRANCH:  state_d = FETCH;
            JUMP:    state_d = FETCH;
            TRAP:    state_d = TRAP;     // left only through reset_n
            default: state_d = RST;      // unused encodings restart cleanly
        endcase
    end

    // ------------------------------------------------------------ output decode
    always_comb begin
        strobes = '0;

        unique case (state_q)
            FETCH: begin
                strobes.mem_req   = 1'b1;
                strobes.alu_src_b = SRC_B_FOUR;
                strobes.alu_op    = ALU_ADD;
                strobes.pc_src    = PC_SRC_ALU;
                // IR and PC load only on the cycle the instruction arrives.
                strobes.ir_write  = ctrl.mem_ready;
                strobes.pc_write  = ctrl.mem_ready;
            end

            DECODE: begin
                // Branch target PC + (imm << 2) is precomputed into ALUOut.
                strobes.alu_src_b = SRC_B_IMM_SH;
                strobes.alu_op    = ALU_ADD;
            end

            MEM_ADDR, I_EXEC: begin
                strobes.alu_src_a = 1'b1;
                strobes.alu_src_b = SRC_B_IMM;
                strobes.alu_op    = ALU_ADD;
            end

            MEM_READ: begin
                strobes.mem_req = 1'b1;
                strobes.iord    = 1'b1;
            end

            MEM_WB: begin
                strobes.reg_write  = 1'b1;
                strobes.mem_to_reg = 1'b1;
            end

            MEM_WRITE: begin
                strobes.mem_req = 1'b1;
                strobes.mem_we  = 1'b1;
                strobes.iord    = 1'b1;
            end

            R_EXEC: begin
                strobes.alu_src_a = 1'b1;
                // Subtraction is A + ~B + 1; slt uses the same difference.
                case (ctrl.funct)
                    FN_SUB: begin
                        strobes.alu_src_b = SRC_B_NOT_B;
                        strobes.alu_cin   = 1'b1;
                    end
                    FN_AND: strobes.alu_op = ALU_AND;
                    FN_OR:  strobes.alu_op = ALU_OR;
                    FN_SLT: begin
                        strobes.alu_src_b = SRC_B_NOT_B;
                        strobes.alu_op    = ALU_SLT;
                        strobes.alu_cin   = 1'b1;
                    end
                    default: strobes.alu_op = ALU_ADD;
                endcase
            end

            R_WB: begin
                strobes.reg_write = 1'b1;
                strobes.reg_dst   = 1'b1;
            end

            I_WB: strobes.reg_write = 1'b1;

            BRANCH: begin
                strobes.alu_src_a     = 1'b1;
                strobes.alu_src_b     = SRC_B_NOT_B;
                strobes.alu_op        = ALU_ADD;
                strobes.alu_cin       = 1'b1;
                strobes.pc_write_cond = 1'b1;
                strobes.pc_src        = PC_SRC_ALUOUT;
            end

            JUMP: begin
                strobes.pc_write = 1'b1;
                strobes.pc_src   = PC_SRC_JUMP;
            end

            TRAP: strobes.trap = 1'b1;

            default: strobes = '0;
        endcase
    end

    assign ctrl.mem_req       = strobes.mem_req;
    assign ctrl.mem_we        = strobes.mem_we;
    assign ctrl.iord          = strobes.iord;
    assign ctrl.ir_write      = strobes.ir_write;
    assign ctrl.alu_src_a     = strobes.alu_src_a;
    assign ctrl.alu_src_b     = strobes.alu_src_b;
    assign ctrl.alu_op        = strobes.alu_op;
    assign ctrl.alu_cin       = strobes.alu_cin;
    assign ctrl.pc_write      = strobes.pc_write;
    assign ctrl.pc_write_cond = strobes.pc_write_cond;
    assign ctrl.pc_src        = strobes.pc_src;
    assign ctrl.reg_write     = strobes.reg_write;
    assign ctrl.reg_dst       = strobes.reg_dst;
    assign ctrl.mem_to_reg    = strobes.mem_to_reg;
    assign ctrl.trap          = strobes.trap;
    // cause_q is only written on entry to TRAP, so it reads 0 everywhere else.
    assign ctrl.trap_cause    = cause_q;
    assign ctrl.state_dbg     = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl_fsm
// Directed, table-driven bench for mc_ctrl_fsm (MEM_TIMEOUT = 4). Each row sets
// the inputs for one cycle and names the hand-computed outputs for that cycle;
// hand-written sequences cover the long trap hold, watchdog boundary and
// asynchronous reset in the middle of a store.
// -----------------------------------------------------------------------------
module tb_mc_ctrl_fsm;

    // Observed outputs, packed for single-shot comparison.
    typedef struct packed {
        logic [3:0] state;
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       alu_src_a;
        logic [2:0] alu_src_b;
        logic [2:0] alu_op;
        logic       alu_cin;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       trap;
        logic [1:0] trap_cause;
    } outs_t;

    typedef struct {
        logic       rst_n;
        logic [5:0] opcode;
        logic [5:0] funct;
        logic       ready;
        outs_t      exp;
        string      name;
    } vec_t;

    // Expected outputs per state (state encodings: RST 0, FETCH 1, DECODE 2,
    // MEM_ADDR 3, MEM_READ 4, MEM_WB 5, MEM_WRITE 6, R_EXEC 7, R_WB 8,
    // I_EXEC 9, I_WB 10, BRANCH 11, JUMP 12, TRAP 13).
    localparam outs_t E_RST      = '0;
    localparam outs_t E_FETCH_W  = '{state: 4'd1, mem_req: 1'b1, alu_src_b: 3'd1, default: '0};
    localparam outs_t E_FETCH_GO = '{state: 4'd1, mem_req: 1'b1, alu_src_b: 3'd1,
                                     ir_write: 1'b1, pc_write: 1'b1, default: '0};
    localparam outs_t E_DECODE   = '{state: 4'd2, alu_src_b: 3'd3, default: '0};
    localparam outs_t E_MEM_ADDR = '{state: 4'd3, alu_src_a: 1'b1, alu_src_b: 3'd2, default: '0};
    localparam outs_t E_MEM_READ = '{state: 4'd4, mem_req: 1'b1, iord: 1'b1, default: '0};
    localparam outs_t E_MEM_WB   = '{state: 4'd5, reg_write: 1'b1, mem_to_reg: 1'b1, default: '0};
    localparam outs_t E_MEM_WR   = '{state: 4'd6, mem_req: 1'b1, mem_we: 1'b1, iord: 1'b1, default: '0};
    localparam outs_t E_R_ADD    = '{state: 4'd7, alu_src_a: 1'b1, default: '0};
    localparam outs_t E_R_SUB    = '{state: 4'd7, alu_src_a: 1'b1, alu_src_b: 3'd4, alu_cin: 1'b1, default: '0};
    localparam outs_t E_R_AND    = '{state: 4'd7, alu_src_a: 1'b1, alu_op: 3'd1, default: '0};
    localparam outs_t E_R_OR     = '{state: 4'd7, alu_src_a: 1'b1, alu_op: 3'd2, default: '0};
    localparam outs_t E_R_SLT    = '{state: 4'd7, alu_src_a: 1'b1, alu_src_b: 3'd4, alu_op: 3'd3,
                                     alu_cin: 1'b1, default: '0};
    localparam outs_t E_R_WB     = '{state: 4'd8, reg_write: 1'b1, reg_dst: 1'b1, default: '0};
    localparam outs_t E_I_EXEC   = '{state: 4'd9, alu_src_a: 1'b1, alu_src_b: 3'd2, default: '0};
    localparam outs_t E_I_WB     = '{state: 4'd10, reg_write: 1'b1, default: '0};
    localparam outs_t E_BRANCH   = '{state: 4'd11, alu_src_a: 1'b1, alu_src_b: 3'd4, alu_cin: 1'b1,
                                     pc_write_cond: 1'b1, pc_src: 2'd1, default: '0};
    localparam outs_t E_JUMP     = '{state: 4'd12, pc_write: 1'b1, pc_src: 2'd2, default: '0};
    localparam outs_t E_TRAP1    = '{state: 4'd13, trap: 1'b1, trap_cause: 2'd1, default: '0};
    localparam outs_t E_TRAP2    = '{state: 4'd13, trap: 1'b1, trap_cause: 2'd2, default: '0};

    logic  clk = 1'b0;
    logic  reset_n;
    outs_t act;
    int    n_cmp  = 0;
    int    n_fail = 0;
    vec_t  tbl[$];

    mc_ctrl_fsm_if bus ();

    mc_ctrl_fsm #(
        .MEM_TIMEOUT (4),
        .TO_W        (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ctrl    (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        act               = '0;
        act.state         = bus.state_dbg;
        act.mem_req       = bus.mem_req;
        act.mem_we        = bus.mem_we;
        act.iord          = bus.iord;
        act.ir_write      = bus.ir_write;
        act.alu_src_a     = bus.alu_src_a;
        act.alu_src_b     = bus.alu_src_b;
        act.alu_op        = bus.alu_op;
        act.alu_cin       = bus.alu_cin;
        act.pc_write      = bus.pc_write;
        act.pc_write_cond = bus.pc_write_cond;
        act.pc_src        = bus.pc_src;
        act.reg_write     = bus.reg_write;
        act.reg_dst       = bus.reg_dst;
        act.mem_to_reg    = bus.mem_to_reg;
        act.trap          = bus.trap;
        act.trap_cause    = bus.trap_cause;
    end

    task automatic check(input string name, input outs_t got, input outs_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got state=%0d outs=%h, expected state=%0d outs=%h",
                     name, got.state, got, exp.state, exp);
        end
    endtask

    function automatic void add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                                input logic rdy, input outs_t exp, input string name);
        vec_t v;
        v.rst_n  = r;
        v.opcode = op;
        v.funct  = fn;
        v.ready  = rdy;
        v.exp    = exp;
        v.name   = name;
        tbl.push_back(v);
    endfunction

    task automatic set_in(input logic [5:0] op, input logic [5:0] fn, input logic rdy);
        bus.opcode    = op;
        bus.funct     = fn;
        bus.mem_ready = rdy;
    endtask

    // Called just after a rising edge: check mid-cycle, then advance one edge.
    task automatic tick_check(input string name, input outs_t exp);
        @(negedge clk);
        check(name, act, exp);
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench just after a rising edge with reset released; the FSM
    // is in RST for this cycle.
    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n      = 1'b0;
        bus.alu_zero = 1'b1;
        set_in(6'h00, 6'h00, 1'b0);
        #2;
        check("reset", act, E_RST);
        @(posedge clk);
        #1;

        // sub, zero wait: back in FETCH on cycle 5
        add(1, 6'h00, 6'h22, 1, E_RST,      "sub_rst");
        add(1, 6'h00, 6'h22, 1, E_FETCH_GO, "sub_fetch");
        add(1, 6'h00, 6'h22, 1, E_DECODE,   "sub_decode");
        add(1, 6'h00, 6'h22, 1, E_R_SUB,    "sub_exec");
        add(1, 6'h00, 6'h22, 1, E_R_WB,     "sub_wb");
        // lw with three wait cycles in MEM_READ: 8 cycles
        add(1, 6'h23, 6'h00, 1, E_FETCH_GO, "lw_fetch");
        add(1, 6'h23, 6'h00, 1, E_DECODE,   "lw_decode");
        add(1, 6'h23, 6'h00, 1, E_MEM_ADDR, "lw_addr");
        add(1, 6'h23, 6'h00, 0, E_MEM_READ, "lw_read_w1");
        add(1, 6'h23, 6'h00, 0, E_MEM_READ, "lw_read_w2");
        add(1, 6'h23, 6'h00, 0, E_MEM_READ, "lw_read_w3");
        add(1, 6'h23, 6'h00, 1, E_MEM_READ, "lw_read_go");
        add(1, 6'h23, 6'h00, 1, E_MEM_WB,   "lw_wb");
        // beq: 3 cycles
        add(1, 6'h04, 6'h00, 1, E_FETCH_GO, "beq_fetch");
        add(1, 6'h04, 6'h00, 1, E_DECODE,   "beq_decode");
        add(1, 6'h04, 6'h00, 1, E_BRANCH,   "beq_branch");
        // sw: 4 cycles
        add(1, 6'h2B, 6'h00, 1, E_FETCH_GO, "sw_fetch");
        add(1, 6'h2B, 6'h00, 1, E_DECODE,   "sw_decode");
        add(1, 6'h2B, 6'h00, 1, E_MEM_ADDR, "sw_addr");
        add(1, 6'h2B, 6'h00, 1, E_MEM_WR,   "sw_write");
        // addi: 4 cycles
        add(1, 6'h08, 6'h00, 1, E_FETCH_GO, "addi_fetch");
        add(1, 6'h08, 6'h00, 1, E_DECODE,   "addi_decode");
        add(1, 6'h08, 6'h00, 1, E_I_EXEC,   "addi_exec");
        add(1, 6'h08, 6'h00, 1, E_I_WB,     "addi_wb");
        // j after one fetch wait: ir_write/pc_write only with mem_ready
        add(1, 6'h02, 6'h00, 0, E_FETCH_W,  "j_fetch_wait");
        add(1, 6'h02, 6'h00, 1, E_FETCH_GO, "j_fetch");
        add(1, 6'h02, 6'h00, 1, E_DECODE,   "j_decode");
        add(1, 6'h02, 6'h00, 1, E_JUMP,     "j_jump");
        // remaining R-type functions
        add(1, 6'h00, 6'h20, 1, E_FETCH_GO, "add_fetch");
        add(1, 6'h00, 6'h20, 1, E_DECODE,   "add_decode");
        add(1, 6'h00, 6'h20, 1, E_R_ADD,    "add_exec");
        add(1, 6'h00, 6'h20, 1, E_R_WB,     "add_wb");
        add(1, 6'h00, 6'h24, 1, E_FETCH_GO, "and_fetch");
        add(1, 6'h00, 6'h24, 1, E_DECODE,   "and_decode");
        add(1, 6'h00, 6'h24, 1, E_R_AND,    "and_exec");
        add(1, 6'h00, 6'h24, 1, E_R_WB,     "and_wb");
        add(1, 6'h00, 6'h25, 1, E_FETCH_GO, "or_fetch");
        add(1, 6'h00, 6'h25, 1, E_DECODE,   "or_decode");
        add(1, 6'h00, 6'h25, 1, E_R_OR,     "or_exec");
        add(1, 6'h00, 6'h25, 1, E_R_WB,     "or_wb");
        add(1, 6'h00, 6'h2A, 1, E_FETCH_GO, "slt_fetch");
        add(1, 6'h00, 6'h2A, 1, E_DECODE,   "slt_decode");
        add(1, 6'h00, 6'h2A, 1, E_R_SLT,    "slt_exec");
        add(1, 6'h00, 6'h2A, 1, E_R_WB,     "slt_wb");
        // illegal funct traps after DECODE; reset clears it
        add(1, 6'h00, 6'h21, 1, E_FETCH_GO, "badfn_fetch");
        add(1, 6'h00, 6'h21, 1, E_DECODE,   "badfn_decode");
        add(1, 6'h00, 6'h21, 1, E_TRAP1,    "badfn_trap");
        add(1, 6'h00, 6'h21, 1, E_TRAP1,    "badfn_hold");
        add(0, 6'h08, 6'h00, 1, E_RST,      "badfn_reset");
        add(1, 6'h08, 6'h00, 1, E_RST,      "badfn_release");
        add(1, 6'h08, 6'h00, 1, E_FETCH_GO, "badfn_refetch");

        foreach (tbl[i]) begin
            reset_n = tbl[i].rst_n;
            set_in(tbl[i].opcode, tbl[i].funct, tbl[i].ready);
            @(negedge clk);
            check(tbl[i].name, act, tbl[i].exp);
            @(posedge clk);
            #1;
        end

        // Illegal opcode: trap held for 100 cycles, cleared by async reset.
        do_reset();
        set_in(6'h3F, 6'h00, 1'b1);
        tick_check("ill_rst", E_RST);
        tick_check("ill_fetch", E_FETCH_GO);
        tick_check("ill_decode", E_DECODE);
        for (int i = 0; i < 100; i++) tick_check("ill_hold", E_TRAP1);
        reset_n = 1'b0;
        #1;
        check("ill_clear", act, E_RST);

        // Watchdog: four waiting FETCH cycles, then TRAP(2).
        do_reset();
        set_in(6'h00, 6'h20, 1'b0);
        tick_check("to_rst", E_RST);
        for (int i = 0; i < 4; i++) tick_check("to_wait", E_FETCH_W);
        tick_check("to_trap", E_TRAP2);
        tick_check("to_hold", E_TRAP2);

        // Same, but mem_ready on the fourth cycle wins over the timeout.
        do_reset();
        set_in(6'h00, 6'h20, 1'b0);
        tick_check("tor_rst", E_RST);
        for (int i = 0; i < 3; i++) tick_check("tor_wait", E_FETCH_W);
        bus.mem_ready = 1'b1;
        tick_check("tor_fetch", E_FETCH_GO);
        tick_check("tor_decode", E_DECODE);
        tick_check("tor_exec", E_R_ADD);

        // Reset in the middle of a waiting store: strobes drop without a clock.
        do_reset();
        set_in(6'h2B, 6'h00, 1'b1);
        tick_check("mw_rst", E_RST);
        tick_check("mw_fetch", E_FETCH_GO);
        tick_check("mw_decode", E_DECODE);
        tick_check("mw_addr", E_MEM_ADDR);
        bus.mem_ready = 1'b0;
        tick_check("mw_write_w1", E_MEM_WR);
        #2;
        check("mw_write_w2", act, E_MEM_WR);
        reset_n = 1'b0;
        #1;
        check("mw_async", act, E_RST);
        @(posedge clk);
        #1;
        reset_n       = 1'b1;
        bus.mem_ready = 1'b1;
        tick_check("mw_after_rst", E_RST);
        tick_check("mw_refetch", E_FETCH_GO);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multicycle control FSM, directly upstream of the ALU operand-B mux.
- Drives alu_src_b (the mux select) together with the ALU op, carry-in, PC, IR, memory and register-file strobes.
- Supports the instruction subset R-type add/sub/and/or/slt, addi, lw, sw, beq and j.
- Subtract is the ALU ADD op on operand select 4 (~B) with carry-in 1.

Parameters:
- MEM_TIMEOUT, 255, maximum cycles waited for mem_ready in any memory state; 0 disables the watchdog.
- TO_W, 8, width of the watchdog counter; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26]; stable from the cycle after IR write.
- funct  in  6  IR[5:0].
- alu_zero  in  1  ALU zero flag, consumed only in BRANCH.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  write access when 1.
- iord  out  1  address source: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load IR.
- alu_src_a  out  1  operand A source: 0 = PC, 1 = register A.
- alu_src_b  out  3  operand B select: 0 = B, 1 = const 4, 2 = sign-extended imm, 3 = imm<<2, 4 = ~B.
- alu_op  out  3  ALU operation.
- alu_cin  out  1  ALU carry-in.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load qualified by alu_zero.
- pc_src  out  2  next-PC source: 0 = ALU result, 1 = ALUOut, 2 = jump target.
- reg_write  out  1  register-file write enable.
- reg_dst  out  1  destination register: 0 = rt, 1 = rd.
- mem_to_reg  out  1  write-back data: 0 = ALUOut, 1 = MDR.
- trap  out  1  sticky error flag.
- trap_cause  out  2  0 = none, 1 = illegal opcode/funct, 2 = memory timeout.
- state_dbg  out  4  current state encoding.

Behaviour:
- Reset: reset_n low forces state RST, clears the watchdog, and drives every output to 0 (trap_cause = 0). The first rising edge after release moves RST -> FETCH.
- Output style: outputs are a Moore decode of the state register. The only exceptions are ir_write, pc_write (in FETCH) and the advance out of memory states, which are additionally gated by mem_ready.
- Unlisted outputs are 0 in each state.
- FETCH:
  - mem_req = 1, iord = 0, alu_src_a = 0, alu_src_b = 1, alu_op = ADD, pc_src = 0.
  - On mem_ready: ir_write = 1, pc_write = 1, next state DECODE. Otherwise stay.
- DECODE:
  - alu_src_a = 0, alu_src_b = 3, alu_op = ADD (precomputes the branch target).
  - Next state by opcode: 0x00 -> R_EXEC if funct is in {0x20, 0x22, 0x24, 0x25, 0x2A}, else TRAP(1); 0x23 or 0x2B -> MEM_ADDR; 0x08 -> I_EXEC; 0x04 -> BRANCH; 0x02 -> JUMP; any other opcode -> TRAP(1).
- MEM_ADDR: alu_src_a = 1, alu_src_b = 2, ADD. Next MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: mem_req = 1, iord = 1. Next MEM_WB on mem_ready.
- MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0. Next FETCH.
- MEM_WRITE: mem_req = 1, mem_we = 1, iord = 1. Next FETCH on mem_ready.
- R_EXEC: alu_src_a = 1.
  - add: alu_src_b = 0, ADD, cin 0.
  - sub: alu_src_b = 4, ADD, cin 1.
  - and: alu_src_b = 0, AND.
  - or: alu_src_b = 0, OR.
  - slt: alu_src_b = 4, SLT, cin 1.
  - Next R_WB.
- R_WB: reg_write = 1, reg_dst = 1, mem_to_reg = 0. Next FETCH.
- I_EXEC: alu_src_a = 1, alu_src_b = 2, ADD. Next I_WB.
- I_WB: reg_write = 1, reg_dst = 0. Next FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 4, ADD, cin 1, pc_write_cond = 1, pc_src = 1. Next FETCH. The PC load itself is the datapath's AND with alu_zero.
- JUMP: pc_write = 1, pc_src = 2. Next FETCH.
- TRAP:
  - All strobes 0, trap = 1, trap_cause is held.
  - The FSM remains in TRAP until reset_n is asserted.
- Watchdog:
  - Counts each cycle spent in FETCH, MEM_READ or MEM_WRITE without mem_ready, and clears on any state change.
  - If the count reaches MEM_TIMEOUT with mem_ready still low, next state is TRAP(2).
  - mem_ready in the same cycle as the count reaching MEM_TIMEOUT completes the access normally; mem_ready wins.
- Zero-wait instruction latency: R-type 4 cycles, addi 4, lw 5, sw 4, beq 3, j 3.
- Reset mid-instruction: all strobes drop to 0 immediately (asynchronous); no partial write occurs after reset assertion.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum constants (RST, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, TRAP);
  - opcode and funct constants;
  - ALU op codes (ADD = 0, AND = 1, OR = 2, SLT = 3);
  - ALU-B select codes (B = 0, FOUR = 1, IMM = 2, IMM_SH = 3, NOT_B = 4);
  - trap cause codes.
- One natural sub-module: mc_ctrl_watchdog, holding the timeout counter and the expiry flag.

Test Plan:
- Reset release, mem_ready tied 1, opcode 0x00 funct 0x22 -> FETCH, DECODE, R_EXEC (alu_src_b = 4, alu_cin = 1, alu_op = ADD), R_WB (reg_write = 1, reg_dst = 1), back in FETCH on cycle 5.
- lw (opcode 0x23) with mem_ready delayed 3 cycles in MEM_READ -> mem_req and iord held for 4 cycles; MEM_WB asserts reg_write = 1 with mem_to_reg = 1; total 8 cycles.
- beq (0x04) -> DECODE shows alu_src_b = 3; BRANCH shows alu_src_b = 4, cin = 1, pc_write_cond = 1, pc_src = 1; 3 cycles.
- opcode 0x3F -> TRAP after DECODE with trap = 1, trap_cause = 1; stays there 100 cycles; reset_n low clears trap.
- MEM_TIMEOUT = 4, mem_ready held 0 in FETCH -> TRAP(2) after the 4th wait cycle; a repeat run with mem_ready arriving on that same cycle advances to DECODE instead.
- reset_n asserted mid MEM_WRITE -> mem_we and mem_req fall to 0 without waiting for a clock edge; the next fetch starts from RST -> FETCH.
